// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one DMEM port between the MEM stage (priority) and a DMA/debug requester.
// Optional starvation guard enabled by defining DMEM_ARB_STARVE_GUARD_EN; without it the core
// has strict priority and the DMA can wait indefinitely.
module dmem_arbiter #(
    parameter int DMEM_ADDR_WIDTH = 12,
    parameter int DMEM_WORD_WIDTH = 16,
    parameter int MAX_WAIT        = 8,
    parameter int WAIT_CNT_WIDTH  = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       in_core_load,
    input  logic                       in_core_store,
    input  logic [DMEM_ADDR_WIDTH-1:0] in_core_rd_addr,
    input  logic [DMEM_ADDR_WIDTH-1:0] in_core_wr_addr,
    input  logic [DMEM_WORD_WIDTH-1:0] in_core_wr_word,
    output logic                       out_core_stall,
    input  logic                       in_dma_req,
    input  logic                       in_dma_we,
    input  logic [DMEM_ADDR_WIDTH-1:0] in_dma_addr,
    input  logic [DMEM_WORD_WIDTH-1:0] in_dma_wdata,
    output logic                       out_dma_ack,
    output logic [DMEM_WORD_WIDTH-1:0] out_dma_rdata,
    output logic [DMEM_ADDR_WIDTH-1:0] out_mem_rd_addr,
    output logic [DMEM_ADDR_WIDTH-1:0] out_mem_wr_addr,
    output logic [DMEM_WORD_WIDTH-1:0] out_mem_wr_word,
    output logic                       out_mem_write_en,
    input  logic [DMEM_WORD_WIDTH-1:0] in_mem_rd_word
);

    typedef enum logic {IDLE, ACK} state_e;

    state_e                     state_q, state_d;
    logic                       ack_we_q, ack_we_d;
    logic [DMEM_WORD_WIDTH-1:0] rdata_q, rdata_d;
    logic                       core_req;
    logic                       force_grant;
    logic                       dma_grant;
    logic                       in_ack;

    if (MAX_WAIT < 1 || MAX_WAIT > (1 << WAIT_CNT_WIDTH) - 1) begin : g_bad_cfg
        $error("dmem_arbiter: MAX_WAIT does not fit in WAIT_CNT_WIDTH");
    end

    assign core_req  = in_core_load | in_core_store;
    assign in_ack    = (state_q == ACK);
    // The ack cycle never grants, so the core always owns the port right after a DMA transfer.
    assign dma_grant = !in_ack && in_dma_req && (!core_req || force_grant);

`ifdef DMEM_ARB_STARVE_GUARD_EN
    logic [WAIT_CNT_WIDTH-1:0] wait_cnt_q, wait_cnt_d;

    assign force_grant = (wait_cnt_q == WAIT_CNT_WIDTH'(MAX_WAIT));

    // Count ungranted request cycles, saturating at MAX_WAIT; a grant restarts the count.
    always_comb begin
        wait_cnt_d = dma_grant ? '0 :
                     (in_dma_req && !force_grant) ? wait_cnt_q + 1'b1 : wait_cnt_q;
    end

    // Wait counter register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`else
    assign force_grant = 1'b0;
`endif

    // DMEM port mux; write enable and stall are held low while reset is asserted.
    always_comb begin
        out_mem_rd_addr  = dma_grant ? in_dma_addr  : in_core_rd_addr;
        out_mem_wr_addr  = dma_grant ? in_dma_addr  : in_core_wr_addr;
        out_mem_wr_word  = dma_grant ? in_dma_wdata : in_core_wr_word;
        out_mem_write_en = reset && (dma_grant ? in_dma_we : in_core_store);
        out_core_stall   = reset && dma_grant && core_req;
    end

    // Ack is the ACK state itself; read data arrives from DMEM during that cycle and is kept afterwards.
    always_comb begin
        out_dma_ack   = in_ack;
        out_dma_rdata = in_ack ? (ack_we_q ? '0 : in_mem_rd_word) : rdata_q;
    end

    // Next-state logic: one ACK cycle follows every grant.
    always_comb begin
        state_d  = dma_grant ? ACK : IDLE;
        ack_we_d = dma_grant ? in_dma_we : ack_we_q;
        rdata_d  = in_ack ? out_dma_rdata : rdata_q;
    end

    // FSM and captured DMA read data.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            ack_we_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            ack_we_q <= ack_we_d;
            rdata_q  <= rdata_d;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: randomized scoreboard bench for dmem_arbiter (honours DMEM_ARB_STARVE_GUARD_EN).
module tb_dmem_arbiter;
    localparam int AW   = 12;
    localparam int DW   = 16;
    localparam int MAXW = 8;

    typedef struct packed {
        logic [AW-1:0] ra;
        logic [AW-1:0] wa;
        logic [DW-1:0] ww;
        logic          we;
        logic          st;
        logic          ack;
    } exp_t;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          in_core_load = 1'b0, in_core_store = 1'b0;
    logic [AW-1:0] in_core_rd_addr = '0, in_core_wr_addr = '0;
    logic [DW-1:0] in_core_wr_word = '0;
    logic          out_core_stall;
    logic          in_dma_req = 1'b0, in_dma_we = 1'b0;
    logic [AW-1:0] in_dma_addr = '0;
    logic [DW-1:0] in_dma_wdata = '0;
    logic          out_dma_ack;
    logic [DW-1:0] out_dma_rdata;
    logic [AW-1:0] out_mem_rd_addr, out_mem_wr_addr;
    logic [DW-1:0] out_mem_wr_word;
    logic          out_mem_write_en;
    logic [DW-1:0] in_mem_rd_word = '0;

    logic [DW-1:0] dmem    [0:(1<<AW)-1];
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];

    exp_t          cyc_q[$];
    logic [DW-1:0] ack_q[$];
    int            checks = 0;
    int            errors = 0;
    int            n_ack  = 0;
    bit            m_ack  = 0;
    int            m_wait = 0;
    bit            last_grant = 0;

    always #5 clock = ~clock;

    dmem_arbiter dut (
        .clock(clock), .reset(reset),
        .in_core_load(in_core_load), .in_core_store(in_core_store),
        .in_core_rd_addr(in_core_rd_addr), .in_core_wr_addr(in_core_wr_addr),
        .in_core_wr_word(in_core_wr_word), .out_core_stall(out_core_stall),
        .in_dma_req(in_dma_req), .in_dma_we(in_dma_we), .in_dma_addr(in_dma_addr),
        .in_dma_wdata(in_dma_wdata), .out_dma_ack(out_dma_ack), .out_dma_rdata(out_dma_rdata),
        .out_mem_rd_addr(out_mem_rd_addr), .out_mem_wr_addr(out_mem_wr_addr),
        .out_mem_wr_word(out_mem_wr_word), .out_mem_write_en(out_mem_write_en),
        .in_mem_rd_word(in_mem_rd_word)
    );

    // DMEM with one-cycle read latency, read-before-write.
    always @(posedge clock) begin
        in_mem_rd_word <= dmem[out_mem_rd_addr];
        if (out_mem_write_en) dmem[out_mem_wr_addr] <= out_mem_wr_word;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: one expected record per stepped cycle; DMA read data checked whenever ack is shown.
    always @(negedge clock) begin
        exp_t e;
        if (cyc_q.size() > 0) begin
            e = cyc_q.pop_front();
            chk("mem_rd_addr", 32'(out_mem_rd_addr), 32'(e.ra));
            chk("mem_wr_addr", 32'(out_mem_wr_addr), 32'(e.wa));
            chk("mem_wr_word", 32'(out_mem_wr_word), 32'(e.ww));
            chk("mem_write_en", 32'(out_mem_write_en), 32'(e.we));
            chk("core_stall", 32'(out_core_stall), 32'(e.st));
            chk("dma_ack", 32'(out_dma_ack), 32'(e.ack));
            if (out_dma_ack) begin
                n_ack++;
                if (ack_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL dma_ack_unexpected act=1 exp=0 t=%0t", $time);
                end else begin
                    chk("dma_rdata", 32'(out_dma_rdata), 32'(ack_q.pop_front()));
                end
            end
        end
    end

    // Drive one cycle of inputs, predict the DUT response from the arbitration rules, advance one clock.
    task automatic step(input logic ld, input logic st, input logic [AW-1:0] ra, input logic [AW-1:0] wa,
                        input logic [DW-1:0] ww, input logic rq, input logic dwe,
                        input logic [AW-1:0] da, input logic [DW-1:0] dd);
        exp_t e;
        bit   frc, g;
        in_core_load = ld; in_core_store = st; in_core_rd_addr = ra; in_core_wr_addr = wa;
        in_core_wr_word = ww; in_dma_req = rq; in_dma_we = dwe; in_dma_addr = da; in_dma_wdata = dd;
`ifdef DMEM_ARB_STARVE_GUARD_EN
        frc = (m_wait == MAXW);
`else
        frc = 0;
`endif
        g = !m_ack && rq && (!(ld || st) || frc);
        e.ra  = g ? da : ra;
        e.wa  = g ? da : wa;
        e.ww  = g ? dd : ww;
        e.we  = g ? dwe : st;
        e.st  = g && (ld || st);
        e.ack = m_ack;
        cyc_q.push_back(e);
        if (g) ack_q.push_back(dwe ? '0 : ref_mem[da]);
        if (e.we) ref_mem[e.wa] = e.ww;
        if (g) m_wait = 0;
        else if (rq && m_wait < MAXW) m_wait++;
        m_ack = g;
        last_grant = g;
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, AW'($urandom), AW'($urandom), DW'($urandom), 0, 0, '0, '0);
    endtask

    initial begin
        bit            pend;
        bit            pwe;
        logic [AW-1:0] pa;
        logic [DW-1:0] pd;
        int            n0, gi;
        for (int i = 0; i < (1 << AW); i++) ref_mem[i] = '0;
        // Reset state with core and DMA both requesting.
        in_core_store = 1; in_core_load = 1; in_dma_req = 1;
        #2;
        chk("rst_dma_ack", 32'(out_dma_ack), 0);
        chk("rst_dma_rdata", 32'(out_dma_rdata), 0);
        chk("rst_write_en", 32'(out_mem_write_en), 0);
        chk("rst_stall", 32'(out_core_stall), 0);
        @(posedge clock);
        #1;
        reset = 1;
        // Give the low addresses known contents.
        for (int i = 0; i < 32; i++) step(0, 1, '0, AW'(i), DW'(i * 16'h0913 + 7), 0, 0, '0, '0);
        // Core store, no DMA.
        step(0, 1, '0, 12'h123, 16'hBEEF, 0, 0, '0, '0);
        // DMA read of 0x010 holding 0x5A5A with core idle.
        step(0, 1, '0, 12'h010, 16'h5A5A, 0, 0, '0, '0);
        step(0, 0, '0, '0, '0, 1, 0, 12'h010, '0);
        idle(2);
        // Request held across the ack: grants on alternate cycles.
        for (int i = 0; i < 4; i++) step(0, 0, '0, '0, '0, 1, 0, AW'(5 + i / 2), '0);
        idle(2);
        // Reset asserted during the ack cycle of a granted read.
        step(0, 0, '0, '0, '0, 1, 0, 12'h010, '0);
        reset = 0; in_core_store = 1; in_core_load = 1; in_dma_req = 1;
        #2;
        chk("rst_ack_drop", 32'(out_dma_ack), 0);
        chk("rst_rdata_zero", 32'(out_dma_rdata), 0);
        chk("rst_mid_write_en", 32'(out_mem_write_en), 0);
        chk("rst_mid_stall", 32'(out_core_stall), 0);
        @(posedge clock);
        #1;
        reset = 1;
        ack_q.delete();
        m_ack = 0;
        m_wait = 0;
        step(0, 0, '0, '0, '0, 1, 1, 12'h011, 16'h0F0F);
        idle(2);
        // Core loads every cycle while a DMA write waits.
        n0 = n_ack;
        gi = -1;
        pend = 1;
`ifdef DMEM_ARB_STARVE_GUARD_EN
        for (int i = 0; i < 20; i++) begin
`else
        for (int i = 0; i < 100; i++) begin
`endif
            step(1, 0, AW'($urandom_range(0, 31)), '0, '0, pend, 1, 12'h020, 16'h1234);
            if (last_grant) begin
                pend = 0;
                gi = i;
            end
        end
        #4;
`ifdef DMEM_ARB_STARVE_GUARD_EN
        chk("forced_grant_cycle", 32'(gi), 8);
        chk("forced_ack_count", 32'(n_ack - n0), 1);
`else
        chk("starved_ack_count", 32'(n_ack - n0), 0);
        chk("starved_grant", 32'(gi), 32'hFFFF_FFFF);
        step(0, 0, '0, '0, '0, 1, 1, 12'h020, 16'h1234);
`endif
        idle(2);
        // Random traffic with a protocol-abiding requester.
        pend = 0; pwe = 0; pa = '0; pd = '0;
        for (int i = 0; i < 3000; i++) begin
            if (!pend && $urandom_range(0, 2) == 0) begin
                pend = 1;
                pwe = 1'($urandom_range(0, 1));
                pa = AW'($urandom_range(0, 31));
                pd = DW'($urandom);
            end
            step($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, AW'($urandom_range(0, 31)),
                 AW'($urandom_range(0, 31)), DW'($urandom), pend, pwe, pa, pd);
            if (last_grant) pend = 0;
        end
        idle(2);
        @(negedge clock);
        #1;
        chk("queues_drained", 32'(cyc_q.size() + ack_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
